// File: rtl/sgf_normalizer.sv
// Normalization stage of the FP add/sub datapath: one right shift on carry-out,
// otherwise left shifts one bit per cycle until the hidden bit is set or exp hits 0.
module sgf_normalizer #(
    parameter int W_Sgf = 23,
    parameter int W_Exp = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_Sgf+3:0] sgf_R,
    input  logic [W_Exp-1:0] exp_in,
    output logic [W_Sgf+2:0] sgf_N,
    output logic [W_Exp-1:0] exp_out,
    output logic             zero,
    output logic             overflow,
    output logic             underflow,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold last result
    // CHECK | classify captured sum: carry, zero, normalized, exp==0, or needs shifting
    // SHIFT | one left shift and exponent decrement per cycle
    // DONE  | result registered, done pulse
    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

    localparam int W_WORK = W_Sgf + 4;
    localparam logic [W_Exp-1:0] EXP_MAX = '1;
    localparam logic [W_Exp-1:0] EXP_ONE = {{(W_Exp-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [W_WORK-1:0]   work, work_nxt, work_shl;
    logic [W_Exp-1:0]    exp_cnt, exp_nxt, exp_dec;
    logic                zero_nxt, ovf_nxt, unf_nxt;

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        exp_nxt   = exp_cnt;
        zero_nxt  = zero;
        ovf_nxt   = overflow;
        unf_nxt   = underflow;
        work_shl  = {work[W_WORK-2:0], 1'b0};
        exp_dec   = exp_cnt - EXP_ONE;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nxt  = sgf_R;
                    exp_nxt   = exp_in;
                    zero_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                    unf_nxt   = 1'b0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (work[W_WORK-1]) begin
                    // right shift keeps the dropped bit as sticky in bit0
                    work_nxt = {1'b0, work[W_WORK-1:2], work[1] | work[0]};
                    if (exp_cnt >= EXP_MAX - EXP_ONE) begin
                        exp_nxt = EXP_MAX;
                        ovf_nxt = 1'b1;
                    end else begin
                        exp_nxt = exp_cnt + EXP_ONE;
                    end
                    state_nxt = DONE;
                end else if (work == '0) begin
                    zero_nxt  = 1'b1;
                    exp_nxt   = '0;
                    state_nxt = DONE;
                end else if (work[W_WORK-2]) begin
                    state_nxt = DONE;
                end else if (exp_cnt == '0) begin
                    unf_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                work_nxt = work_shl;
                exp_nxt  = exp_dec;
                if (work_shl[W_WORK-2] || (exp_dec == '0)) state_nxt = DONE;
                if ((exp_dec == '0) && !work_shl[W_WORK-2]) unf_nxt = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            work      <= '0;
            exp_cnt   <= '0;
            sgf_N     <= '0;
            exp_out   <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            exp_cnt   <= exp_nxt;
            zero      <= zero_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
            busy      <= (state_nxt == CHECK) || (state_nxt == SHIFT);
            done      <= (state_nxt == DONE);
            // result is registered on entry to DONE so it is valid with the done pulse
            if ((state_nxt == DONE) && (state != DONE)) begin
                sgf_N   <= work_nxt[W_Sgf+2:0];
                exp_out <= exp_nxt;
            end
        end
    end

endmodule

// File: doc/sgf_normalizer.md
# sgf_normalizer

Sequential normalization stage of the floating-point add/subtract datapath. It consumes the registered significand sum/difference, including its carry-out bit, together with the exponent of the larger operand. It produces a normalized significand (hidden bit at MSB) and the adjusted exponent, plus zero/overflow/underflow flags. It uses a start/done handshake and shifts at most one bit per cycle.

## Interface
- W_Sgf, 23, fraction width (52 for double precision)
- W_Exp, 8, exponent width (11 for double precision)
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- sgf_R  in  W_Sgf+4  add/sub result: [W_Sgf+3] carry, [W_Sgf+2] hidden, [W_Sgf+1:2] fraction, [1:0] guard/round
- exp_in  in  W_Exp  exponent of the larger operand
- sgf_N  out  W_Sgf+3  normalized significand; [W_Sgf+2] is the hidden bit
- exp_out  out  W_Exp  adjusted exponent
- zero  out  1  result significand is zero
- overflow  out  1  exponent reached or passed all-ones
- underflow  out  1  exponent reached 0 before the hidden bit was set
- busy  out  1  high in CHECK or SHIFT
- done  out  1  one-cycle pulse; outputs are valid while it is high

## Operation
- States: IDLE, CHECK, SHIFT, DONE.
- IDLE with start=1: at the next edge, capture sgf_R into a working register (W_Sgf+4 bits) and exp_in into an exponent counter, then go to CHECK. The flags clear at the same edge.
- CHECK, evaluated in priority order:
  - Carry bit = 1: work = work >> 1, with the new bit0 = old bit1 | old bit0 (sticky). exp = exp + 1. If the result is all-ones, or exp_in was already all-ones, exp_out saturates to all-ones and overflow = 1. Go to DONE.
  - work == 0: zero = 1, exp_out = 0, sgf_N = 0. Go to DONE.
  - Hidden bit = 1: no change. Go to DONE.
  - exp == 0: underflow = 1, no shift. Go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT, each edge: work = work << 1 (zero fill), exp = exp - 1.
  - Go to DONE when the post-shift hidden bit = 1, or when the post-shift exp = 0.
  - If exp reaches 0 with the hidden bit still 0, underflow = 1.
- DONE: sgf_N = work[W_Sgf+2:0] and exp_out are registered. done = 1. Next edge goes to IDLE unconditionally.
- After DONE, outputs and flags hold until the next accepted start.
- start is ignored in CHECK, SHIFT and DONE. No queuing.
- The maximum number of left shifts is W_Sgf+2, which occurs when sgf_R has only bit0 set and exp is large enough.

## Timing
- Reset (asynchronous, rst=0): state = IDLE. sgf_N, exp_out, zero, overflow, underflow, busy and done are all 0.
- Reset mid-operation aborts immediately. done is not asserted and outputs return to 0.
- Let start be sampled at edge k, and let n be the number of left shifts (n = 0 for the carry, zero, already-normalized and exp==0 cases).
- done is high in the cycle following edge k+1+n, for exactly one cycle.
- busy is high from edge k until the edge at which DONE is entered.
- Minimum start-to-start spacing is n+3 cycles. start asserted on the cycle done is high is ignored; it is accepted in the following cycle (IDLE).
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Carry: sgf_R=27'h4000001, exp_in=127, start -> done after edge k+1; sgf_N=26'h2000001, exp_out=128, all flags 0.
- Left shift: sgf_R=27'h0800000, exp_in=100 -> n=2, done after edge k+3; sgf_N=26'h2000000, exp_out=98.
- Zero and already normalized:
  - sgf_R=0, exp_in=50 -> zero=1, exp_out=0, sgf_N=0, done after edge k+1.
  - sgf_R=27'h2000000, exp_in=100 -> sgf_N=26'h2000000, exp_out=100.
- Overflow and underflow:
  - Carry with exp_in=254 -> exp_out=255, overflow=1.
  - sgf_R=27'h0000001, exp_in=3 -> three shifts, sgf_N=26'h0000008, exp_out=0, underflow=1.
- Worst case and back-to-back:
  - sgf_R=27'h0000001, exp_in=200 -> n=25, sgf_N=26'h2000000, exp_out=175.
  - start held high continuously -> a second operation is accepted only from IDLE, 28 cycles after the first accept.
- Reset mid-SHIFT: assert rst=0 during shift 5 of a 25-shift job -> busy=0, no done pulse, all outputs 0. The next start completes normally.
